// File: rtl/dilithium_pkg.sv
// Shared widths and arbiter FSM encoding for the eta sampler sharing logic.
package dilithium_pkg;

  localparam int SEED_W  = 512;
  localparam int NONCE_W = 16;
  localparam int POLY_W  = 8192;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_DONE    = 3'd3,
    ST_RELEASE = 3'd4
  } arb_state_e;

endpackage

// File: rtl/eta_sampler_arbiter_rr_arbiter.sv
// Combinational request picker: round-robin from ptr, or fixed lowest-index
// priority when ETA_ARB_FIXED_PRIO_EN is defined (ptr port then absent).
module rr_arbiter
  import dilithium_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0] req,
`ifndef ETA_ARB_FIXED_PRIO_EN
  input  logic [1:0]       ptr,
`endif
  output logic [N_REQ-1:0] gnt,
  output logic [1:0]       gnt_idx,
  output logic             gnt_any
);

  int start_s;
  int idx_s;

  // First requester at or after the start point, wrapping modulo N_REQ.
  always_comb begin
    gnt     = '0;
    gnt_idx = 2'd0;
    gnt_any = 1'b0;
    idx_s   = 0;
`ifdef ETA_ARB_FIXED_PRIO_EN
    start_s = 0;
`else
    start_s = int'(ptr);
`endif
    for (int i = 0; i < N_REQ; i++) begin
      idx_s = (start_s + i) % N_REQ;
      if (!gnt_any && (|(req & (N_REQ'(1'b1) << idx_s)))) begin
        gnt     = N_REQ'(1'b1) << idx_s;
        gnt_idx = 2'(idx_s);
        gnt_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/eta_sampler_arbiter.sv
// Shares one poly_uniform_eta sampler among N_REQ requesters over rtr/rts
// handshakes. Optional macro ETA_ARB_FIXED_PRIO_EN selects fixed priority.
module eta_sampler_arbiter
  import dilithium_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req_rtr,
  input  logic [N_REQ*SEED_W-1:0]  req_linear_seed,
  input  logic [N_REQ*NONCE_W-1:0] req_nonce,
  output logic [N_REQ-1:0]         req_rts,
  output logic [POLY_W-1:0]        linear_a,
  output logic [1:0]               gnt_id,
  output logic                     busy,
  output logic                     smp_rtr,
  output logic [SEED_W-1:0]        smp_linear_seed,
  output logic [NONCE_W-1:0]       smp_nonce,
  input  logic [POLY_W-1:0]        smp_linear_a,
  input  logic                     smp_rts
);

  arb_state_e          state_q, state_d;
  logic [1:0]          gnt_id_q, gnt_id_d;
  logic [SEED_W-1:0]   seed_q, seed_d;
  logic [NONCE_W-1:0]  nonce_q, nonce_d;
  logic [POLY_W-1:0]   linear_a_q, linear_a_d;
`ifndef ETA_ARB_FIXED_PRIO_EN
  logic [1:0]          rr_ptr_q, rr_ptr_d;
`endif

  logic [N_REQ-1:0]    arb_gnt_s;
  logic [1:0]          arb_idx_s;
  logic                arb_any_s;
  logic [N_REQ-1:0]    gnt_oh_s;
  logic                cur_rtr_s;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr_arbiter (
    .req     (req_rtr),
`ifndef ETA_ARB_FIXED_PRIO_EN
    .ptr     (rr_ptr_q),
`endif
    .gnt     (arb_gnt_s),
    .gnt_idx (arb_idx_s),
    .gnt_any (arb_any_s)
  );

  assign gnt_oh_s  = N_REQ'(1'b1) << gnt_id_q;
  assign cur_rtr_s = |(req_rtr & gnt_oh_s);

  // Next-state and datapath capture; seed/nonce are latched only on a grant in IDLE.
  always_comb begin
    state_d    = state_q;
    gnt_id_d   = gnt_id_q;
    seed_d     = seed_q;
    nonce_d    = nonce_q;
    linear_a_d = linear_a_q;
`ifndef ETA_ARB_FIXED_PRIO_EN
    rr_ptr_d   = rr_ptr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (arb_any_s) begin
          gnt_id_d = arb_idx_s;
          for (int r = 0; r < N_REQ; r++) begin
            if (|(arb_gnt_s & (N_REQ'(1'b1) << r))) begin
              seed_d  = SEED_W'(req_linear_seed >> (r * SEED_W));
              nonce_d = NONCE_W'(req_nonce >> (r * NONCE_W));
            end
          end
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (smp_rts) begin
          linear_a_d = smp_linear_a;
`ifndef ETA_ARB_FIXED_PRIO_EN
          rr_ptr_d   = (gnt_id_q == 2'(N_REQ - 1)) ? 2'd0 : gnt_id_q + 2'd1;
`endif
          // A requester that withdrew mid-job never sees its result.
          state_d    = cur_rtr_s ? ST_DONE : ST_RELEASE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DONE:    state_d = cur_rtr_s ? ST_DONE : ST_RELEASE;
      ST_RELEASE: state_d = smp_rts ? ST_RELEASE : ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      gnt_id_q   <= 2'd0;
      seed_q     <= '0;
      nonce_q    <= '0;
      linear_a_q <= '0;
`ifndef ETA_ARB_FIXED_PRIO_EN
      rr_ptr_q   <= 2'd0;
`endif
    end else begin
      state_q    <= state_d;
      gnt_id_q   <= gnt_id_d;
      seed_q     <= seed_d;
      nonce_q    <= nonce_d;
      linear_a_q <= linear_a_d;
`ifndef ETA_ARB_FIXED_PRIO_EN
      rr_ptr_q   <= rr_ptr_d;
`endif
    end
  end

  assign busy            = (state_q != ST_IDLE);
  assign smp_rtr         = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign req_rts         = (state_q == ST_DONE) ? gnt_oh_s : '0;
  assign linear_a        = linear_a_q;
  assign gnt_id          = gnt_id_q;
  assign smp_linear_seed = seed_q;
  assign smp_nonce       = nonce_q;

endmodule

// File: tb/tb_eta_sampler_arbiter.sv
// Scoreboard bench for eta_sampler_arbiter with a behavioural sampler of
// programmable latency and a reference grant-order model.
module tb_eta_sampler_arbiter;
  import dilithium_pkg::*;

  localparam int N = 2;

  logic                 clock = 1'b0;
  logic                 reset = 1'b0;
  logic [N-1:0]         req_rtr;
  logic [N*SEED_W-1:0]  req_linear_seed;
  logic [N*NONCE_W-1:0] req_nonce;
  logic [N-1:0]         req_rts;
  logic [POLY_W-1:0]    linear_a;
  logic [1:0]           gnt_id;
  logic                 busy;
  logic                 smp_rtr;
  logic [SEED_W-1:0]    smp_linear_seed;
  logic [NONCE_W-1:0]   smp_nonce;
  logic [POLY_W-1:0]    smp_linear_a;
  logic                 smp_rts;

  logic                 rtr_v   [N];
  logic [SEED_W-1:0]    seed_v  [N];
  logic [NONCE_W-1:0]   nonce_v [N];

  for (genvar g = 0; g < N; g++) begin : g_drv
    assign req_rtr[g]                            = rtr_v[g];
    assign req_linear_seed[g*SEED_W +: SEED_W]   = seed_v[g];
    assign req_nonce[g*NONCE_W +: NONCE_W]       = nonce_v[g];
  end

  always #5 clock = ~clock;

  eta_sampler_arbiter #(.N_REQ(N)) dut (
    .clock           (clock),
    .reset           (reset),
    .req_rtr         (req_rtr),
    .req_linear_seed (req_linear_seed),
    .req_nonce       (req_nonce),
    .req_rts         (req_rts),
    .linear_a        (linear_a),
    .gnt_id          (gnt_id),
    .busy            (busy),
    .smp_rtr         (smp_rtr),
    .smp_linear_seed (smp_linear_seed),
    .smp_nonce       (smp_nonce),
    .smp_linear_a    (smp_linear_a),
    .smp_rts         (smp_rts)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [POLY_W-1:0] poly_fn(input logic [SEED_W-1:0] s,
                                                input logic [NONCE_W-1:0] n);
    logic [POLY_W-1:0] p;
    for (int i = 0; i < 256; i++)
      p[i*32 +: 32] = s[(i%16)*32 +: 32] ^ {n, 8'(i), 8'h5A};
    return p;
  endfunction

  function automatic logic [SEED_W-1:0] rand_seed();
    logic [SEED_W-1:0] s;
    for (int k = 0; k < SEED_W/32; k++) s[k*32 +: 32] = $urandom;
    return s;
  endfunction

  function automatic bit rts_bit(input int r);
    return ((req_rts >> r) & N'(1)) != '0;
  endfunction

  // Reference arbitration: first requesting index scanning upward from ptr.
  function automatic int ref_pick(input logic [N-1:0] req, input int ptr);
    int start;
`ifdef ETA_ARB_FIXED_PRIO_EN
    start = 0;
`else
    start = ptr;
`endif
    for (int k = 0; k < N; k++)
      if (req[(start + k) % N]) return (start + k) % N;
    return -1;
  endfunction

  // Behavioural sampler: rts after lat_cur cycles of rtr, held until rtr drops.
  int lat_fix  = 10;
  bit lat_rand = 1'b0;
  int lat_cur  = 10;
  int smp_cnt;
  always @(posedge clock) begin
    if (!reset) begin
      smp_rts      <= 1'b0;
      smp_cnt      <= 0;
      smp_linear_a <= '0;
    end else if (!smp_rts) begin
      if (smp_rtr) begin
        if (smp_cnt + 1 >= lat_cur) begin
          smp_rts      <= 1'b1;
          smp_linear_a <= poly_fn(smp_linear_seed, smp_nonce);
          smp_cnt      <= 0;
        end else begin
          smp_cnt <= smp_cnt + 1;
        end
      end
    end else if (!smp_rtr) begin
      smp_rts <= 1'b0;
    end
  end

  // Grant monitor: checks each new grant against the reference model.
  logic [N-1:0] req_at_edge;
  always @(posedge clock) req_at_edge <= req_rtr;

  int ptr_m = 0;
  bit prev_smp_rtr = 1'b0;
  int run_len = 0;
  int last_run = 0;
  int grant_log[$];
  always @(negedge clock) begin
    int e;
    if (smp_rtr) run_len++;
    else if (prev_smp_rtr) begin
      last_run = run_len;
      run_len  = 0;
    end
    if (smp_rtr && !prev_smp_rtr) begin
      e = ref_pick(req_at_edge, ptr_m);
      if (e < 0) begin
        n_vec++; n_err++;
        $display("FAIL grant_unexpected: got gnt_id %0d with no request", gnt_id);
      end else begin
        chk("grant_id", 64'(gnt_id), 64'(e));
        chk("grant_nonce", 64'(smp_nonce), 64'(nonce_v[e]));
        n_vec++;
        if (smp_linear_seed !== seed_v[e]) begin
          n_err++;
          $display("FAIL grant_seed: got %0h expected %0h", smp_linear_seed[63:0], seed_v[e][63:0]);
        end
        ptr_m = (e + 1) % N;
      end
      grant_log.push_back(int'(gnt_id));
      lat_cur = lat_rand ? int'($urandom_range(1, 6)) : lat_fix;
    end
    prev_smp_rtr = smp_rtr;
  end

  // Result monitor: pops the scoreboard on every rising req_rts bit.
  logic [POLY_W-1:0] exp_q[N][$];
  logic [N-1:0] prev_rts = '0;
  always @(negedge clock) begin
    logic [POLY_W-1:0] ex;
    for (int r = 0; r < N; r++) begin
      if (rts_bit(r) && !prev_rts[r]) begin
        if (exp_q[r].size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL rts_unexpected: got req_rts %b expected no result for requester %0d", req_rts, r);
        end else begin
          ex = exp_q[r].pop_front();
          n_vec++;
          if (linear_a !== ex) begin
            n_err++;
            $display("FAIL result_poly%0d: got %0h expected %0h", r, linear_a[63:0], ex[63:0]);
          end
          chk("rts_onehot", 64'(req_rts), 64'(N'(1) << r));
        end
      end
    end
    prev_rts = req_rts;
  end

  task automatic serve(input int r, input logic [NONCE_W-1:0] nonce, input int hold);
    int t;
    @(negedge clock);
    seed_v[r]  = rand_seed();
    nonce_v[r] = nonce;
    exp_q[r].push_back(poly_fn(seed_v[r], nonce_v[r]));
    rtr_v[r]   = 1'b1;
    t = 0;
    while (!rts_bit(r) && t < 3000) begin
      @(negedge clock);
      t++;
    end
    if (t >= 3000) begin
      n_vec++; n_err++;
      $display("FAIL serve_timeout%0d: got no req_rts expected req_rts within 3000 cycles", r);
      if (exp_q[r].size() > 0) void'(exp_q[r].pop_back());
    end
    repeat (hold) @(negedge clock);
    rtr_v[r] = 1'b0;
  endtask

  task automatic do_reset(input int n);
    @(negedge clock);
    reset = 1'b0;
    ptr_m = 0;
    repeat (n) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic wait_grant(input string nm);
    int t = 0;
    while (!smp_rtr && t < 200) begin
      @(negedge clock);
      t++;
    end
    chk(nm, 64'(t < 200), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before 50000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [SEED_W-1:0] old_seed;
    logic [N-1:0]      seen;
    int t;
    for (int r = 0; r < N; r++) begin
      rtr_v[r] = 1'b0; seed_v[r] = '0; nonce_v[r] = '0;
    end
    do_reset(3);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_smp_rtr", 64'(smp_rtr), 64'd0);
    chk("rst_req_rts", 64'(req_rts), 64'd0);
    chk("rst_gnt_id", 64'(gnt_id), 64'd0);
    chk("rst_linear_a", 64'(|linear_a), 64'd0);
    chk("rst_smp_nonce", 64'(smp_nonce), 64'd0);
    chk("rst_smp_seed", 64'(|smp_linear_seed), 64'd0);

    // single request, latency 10
    serve(0, 16'h0003, 0);
    chk("single_nonce", 64'(smp_nonce), 64'h3);
    @(negedge clock);
    chk("single_busy_1", 64'(busy), 64'd1);
    @(negedge clock);
    chk("single_busy_2", 64'(busy), 64'd0);
    chk("single_rtr_len", 64'(last_run), 64'd11);

    // simultaneous requests straight from reset
    do_reset(2);
    grant_log.delete();
    fork
      serve(0, 16'($urandom), 2);
      serve(1, 16'($urandom), 2);
    join
    chk("simul_count", 64'(grant_log.size()), 64'd2);
    chk("simul_first", 64'(grant_log[0]), 64'd0);
    chk("simul_second", 64'(grant_log[1]), 64'd1);

`ifdef ETA_ARB_FIXED_PRIO_EN
    do_reset(2);
    grant_log.delete();
    fork
      begin serve(0, 16'($urandom), 0); serve(0, 16'($urandom), 0); end
      serve(1, 16'($urandom), 0);
    join
    chk("fixed_count", 64'(grant_log.size()), 64'd3);
    chk("fixed_order0", 64'(grant_log[0]), 64'd0);
    chk("fixed_order1", 64'(grant_log[1]), 64'd0);
    chk("fixed_order2", 64'(grant_log[2]), 64'd1);
`endif

    // fairness: both requesters re-raise five times, random sampler latency
    lat_rand = 1'b1;
    do_reset(2);
    grant_log.delete();
    fork
      for (int k = 0; k < 5; k++) serve(0, 16'($urandom), int'($urandom_range(0, 2)));
      for (int k = 0; k < 5; k++) serve(1, 16'($urandom), int'($urandom_range(0, 2)));
    join
    chk("fair_count", 64'(grant_log.size()), 64'd10);
`ifndef ETA_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 10; i++) chk("fair_order", 64'(grant_log[i]), 64'(i % 2));
`endif
    lat_rand = 1'b0;

    // withdrawal during WAIT discards the result
    lat_fix = 20;
    @(negedge clock);
    seed_v[1] = rand_seed(); nonce_v[1] = 16'($urandom); rtr_v[1] = 1'b1;
    wait_grant("withdraw_grant");
    repeat (3) @(negedge clock);
    rtr_v[1] = 1'b0;
    seen = '0;
    t = 0;
    while (busy && t < 100) begin
      seen |= req_rts;
      @(negedge clock);
      t++;
    end
    chk("withdraw_rts", 64'(seen), 64'd0);
    chk("withdraw_idle", 64'(busy), 64'd0);
    lat_fix = 4;
    serve(0, 16'($urandom), 1);

    // reset during WAIT aborts silently
    lat_fix = 20;
    @(negedge clock);
    seed_v[0] = rand_seed(); nonce_v[0] = 16'($urandom); rtr_v[0] = 1'b1;
    wait_grant("rstwait_grant");
    repeat (4) @(negedge clock);
    reset = 1'b0; rtr_v[0] = 1'b0; ptr_m = 0;
    @(negedge clock);
    reset = 1'b1;
    chk("rstwait_smp_rtr", 64'(smp_rtr), 64'd0);
    chk("rstwait_req_rts", 64'(req_rts), 64'd0);
    chk("rstwait_busy", 64'(busy), 64'd0);
    chk("rstwait_linear_a", 64'(|linear_a), 64'd0);
    lat_fix = 5;
    serve(1, 16'($urandom), 1);

    // seed isolation: slice changes after the grant do not reach the sampler
    lat_fix = 15;
    @(negedge clock);
    seed_v[0] = rand_seed(); nonce_v[0] = 16'($urandom);
    exp_q[0].push_back(poly_fn(seed_v[0], nonce_v[0]));
    rtr_v[0] = 1'b1;
    wait_grant("iso_grant");
    repeat (3) @(negedge clock);
    old_seed  = seed_v[0];
    seed_v[0] = ~old_seed;
    repeat (2) @(negedge clock);
    n_vec++;
    if (smp_linear_seed !== old_seed) begin
      n_err++;
      $display("FAIL iso_seed: got %0h expected %0h", smp_linear_seed[63:0], old_seed[63:0]);
    end
    t = 0;
    while (!rts_bit(0) && t < 200) begin
      @(negedge clock);
      t++;
    end
    chk("iso_done", 64'(t < 200), 64'd1);
    rtr_v[0] = 1'b0;
    lat_fix = 3;
    serve(0, 16'($urandom), 0);

    repeat (5) @(negedge clock);
    for (int r = 0; r < N; r++) chk("sb_empty", 64'(exp_q[r].size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/eta_sampler_arbiter.md
Name: eta_sampler_arbiter

Overview:
- Shares one poly_uniform_eta sampler between N_REQ independent requesters, e.g. the s1 (L=5) and s2 (K=6) secret-vector generators of key generation.
- Each requester presents seed and nonce under an rtr/rts level handshake. The arbiter grants round-robin, drives the sampler, captures its 8192-bit polynomial, and returns it to the granted requester.
- Sits between the polyvec controllers and the single sampler instance.

Parameters:
- N_REQ, 2, number of requesters (2..4).
- SEED_W, 512, seed width.
- NONCE_W, 16, nonce width.
- POLY_W, 8192, polynomial width (256 coeffs x 32 bit).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- req_rtr  in  N_REQ  per-requester request level; seed and nonce stable while high.
- req_linear_seed  in  N_REQ*SEED_W  requester r in slice [r*SEED_W +: SEED_W].
- req_nonce  in  N_REQ*NONCE_W  requester r in slice [r*NONCE_W +: NONCE_W].
- req_rts  out  N_REQ  one-hot result-ready, held until that req_rtr drops.
- linear_a  out  POLY_W  captured polynomial, valid while any req_rts bit is high.
- gnt_id  out  2  index of the current or last grant.
- busy  out  1  high in every state except IDLE.
- smp_rtr  out  1  to sampler rtr.
- smp_linear_seed  out  SEED_W  latched seed to sampler.
- smp_nonce  out  NONCE_W  latched nonce to sampler.
- smp_linear_a  in  POLY_W  sampler result.
- smp_rts  in  1  sampler done.

Behaviour:
- Reset (reset==0 at an edge):
  - state=IDLE; rr_ptr=0; gnt_id=0.
  - req_rts=0, smp_rtr=0, busy=0.
  - linear_a, smp_linear_seed and smp_nonce cleared to 0.
  - Reset mid-operation aborts silently. The sampler shares the same reset.
- All outputs are registered or Moore-decoded from registered state. There is no combinational path from inputs to outputs.
- FSM states: IDLE, ISSUE, WAIT, DONE, RELEASE.
  - IDLE: pick the first r with req_rtr[r]=1, scanning from rr_ptr upward modulo N_REQ. If one is found, latch gnt_id=r, smp_linear_seed and smp_nonce from slice r, then go to ISSUE.
  - ISSUE: smp_rtr=1 for one cycle, then go to WAIT.
  - WAIT: smp_rtr stays 1. On smp_rts=1: linear_a<=smp_linear_a, smp_rtr<=0, rr_ptr<=(gnt_id+1) mod N_REQ.
    - If req_rtr[gnt_id] is still 1, go to DONE.
    - Otherwise go to RELEASE and discard the result (no req_rts pulse).
  - DONE: req_rts[gnt_id]=1. Go to RELEASE when req_rtr[gnt_id]==0.
  - RELEASE: req_rts=0, smp_rtr=0. Go to IDLE once smp_rts==0, which guarantees the sampler has returned to idle.
- Latency: request seen in IDLE at edge t gives smp_rtr high from t+1. smp_rts seen at edge u gives req_rts high from u+1.
- Minimum re-grant gap: 2 cycles after req_rtr drops (RELEASE, then IDLE).
- A requester withdrawing before it is granted has no effect.
- Simultaneous requests: rr_ptr breaks the tie. Each requester is served at most once per N_REQ grants while others wait.
- Input changes on non-granted slices during a grant are ignored. Seed and nonce are latched once, in IDLE.
- gnt_id keeps its last value in IDLE.

Optional Feature:
- ETA_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins. rr_ptr is not implemented and the IDLE scan always starts at 0.
- Undefined (default): round-robin as above.

Decomposition:
- Shared package dilithium_pkg:
  - SEED_W, NONCE_W, POLY_W.
  - FSM state encoding constants (IDLE=0 .. RELEASE=4, 3-bit).
- One natural sub-module, rr_arbiter: N_REQ request bits plus rr_ptr in, one-hot grant plus index out. Purely combinational; ETA_ARB_FIXED_PRIO_EN is handled inside it.
- Bench uses a behavioural sampler model with programmable latency.

Test Plan:
- Single request: req_rtr=01, nonce0=16'h0003, sampler latency 10 -> smp_nonce=3, smp_rtr high 11 cycles, req_rts=01 and linear_a=model output. Drop req_rtr -> busy=0 after 2 cycles.
- Simultaneous: req_rtr=11 from reset -> grant 0 first, then 1 (gnt_id 0 then 1). With ETA_ARB_FIXED_PRIO_EN and req0 re-raised immediately -> req0 served twice before req1.
- Fairness: both requesters hold and re-raise 5 times each -> grant order alternates 0,1,0,1..., 10 grants, nonces match per requester.
- Withdrawal in WAIT: drop req_rtr[1] 3 cycles after ISSUE -> req_rts stays 00, FSM returns to IDLE, next grant proceeds normally.
- Reset mid-WAIT: reset=0 for 1 cycle -> smp_rtr=0, req_rts=0, busy=0 next cycle. A following request completes correctly.
- Seed isolation: change req_linear_seed slice 0 during WAIT -> smp_linear_seed unchanged until the next IDLE grant.
